fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the fetch PC, drives a combinational instruction memory, buffers fetched
// instructions in a small circular queue and presents the queue head to IF/ID
// with a valid/stall handshake. A redirect flushes the queue and reloads the PC.
//
// Ports:
//   clk          pipeline clock, rising edge
//   resetl       asynchronous active-low reset
//   startpc      PC loaded while resetl is low
//   imem_addr    instruction memory address (= fetch PC)
//   imem_data    instruction returned combinationally for imem_addr
//   redirect     taken branch: flush queue, reload PC from redirect_pc
//   redirect_pc  branch target (low two bits ignored)
//   stall        downstream cannot accept the head instruction this cycle
//   if_valid     queue head holds a valid instruction
//   if_instr     head instruction (0 when not valid)
//   if_nextseqpc head instruction address + 4 (0 when not valid)
//   currentpc    current fetch PC (= imem_addr)
module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetl,
    input  logic [63:0] startpc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_nextseqpc,
    output logic [63:0] currentpc
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

    logic [63:0]     fpc_q, fpc_d, fpc_plus4;
    logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    logic [31:0] instr_mem [QUEUE_DEPTH];
    logic [63:0] nsp_mem   [QUEUE_DEPTH];

    // Targets are word aligned by dropping the two LSBs.
    logic unused_rpc_lsbs;
    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    assign fpc_plus4 = fpc_q + 64'd4;
    assign if_valid  = (count_q != '0);
    assign pop       = if_valid & ~stall & ~redirect;
    // A full queue can still accept a word when the head leaves the same cycle.
    assign push      = ~redirect & ((count_q < CntW'(QUEUE_DEPTH)) | pop);

    always_comb begin
        fpc_d   = fpc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (redirect) begin
            fpc_d   = {redirect_pc[63:2], 2'b00};
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fpc_d  = fpc_plus4;
                wptr_d = wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            fpc_q   <= startpc;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wptr_q] <= imem_data;
            nsp_mem[wptr_q]   <= fpc_plus4;
        end
    end

    assign imem_addr    = fpc_q;
    assign currentpc    = fpc_q;
    assign if_instr     = if_valid ? instr_mem[rptr_q] : 32'h0;
    assign if_nextseqpc = if_valid ? nsp_mem[rptr_q] : 64'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table with hand-derived
// expectations plus a queue-based scoreboard checked every cycle.
module tb_fetch_unit;

    localparam int unsigned Depth = 2;

    logic        clk = 1'b0;
    logic        resetl;
    logic [63:0] startpc;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_nextseqpc;
    logic [63:0] currentpc;

    fetch_unit #(.QUEUE_DEPTH(Depth)) dut (
        .clk          (clk),
        .resetl       (resetl),
        .startpc      (startpc),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .stall        (stall),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_nextseqpc (if_nextseqpc),
        .currentpc    (currentpc)
    );

    always #5 clk = ~clk;

    // Memory word = its own address.
    assign imem_data = imem_addr[31:0];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] nsp;
    } ent_t;

    ent_t        sb_q[$];
    logic [63:0] m_fpc;

    task automatic model_reset(input logic [63:0] spc);
        sb_q.delete();
        m_fpc = spc;
    endtask

    // Called right after a rising edge, with the inputs that edge sampled.
    task automatic model_step();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (redirect) begin
            sb_q.delete();
            m_fpc = {redirect_pc[63:2], 2'b00};
        end else begin
            do_pop  = (sb_q.size() != 0) && !stall;
            do_push = (sb_q.size() < Depth) || do_pop;
            if (do_pop) void'(sb_q.pop_front());
            if (do_push) begin
                e.instr = m_fpc[31:0];
                e.nsp   = m_fpc + 64'd4;
                sb_q.push_back(e);
                m_fpc = m_fpc + 64'd4;
            end
        end
    endtask

    task automatic model_check(input string tag);
        bit exp_v;
        exp_v = (sb_q.size() != 0);
        chk({tag, " sb.valid"}, 64'(if_valid), 64'(exp_v));
        chk({tag, " sb.instr"}, 64'(if_instr), exp_v ? 64'(sb_q[0].instr) : 64'h0);
        chk({tag, " sb.nsp"}, if_nextseqpc, exp_v ? sb_q[0].nsp : 64'h0);
        chk({tag, " sb.pc"}, currentpc, m_fpc);
        chk({tag, " sb.imem_addr"}, imem_addr, m_fpc);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        model_check(tag);
    endtask

    task automatic apply_reset(input logic [63:0] spc);
        @(negedge clk);
        resetl      = 1'b0;
        startpc     = spc;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        stall       = 1'b0;
        model_reset(spc);
        #1;
        chk("reset valid", 64'(if_valid), 64'h0);
        chk("reset instr", 64'(if_instr), 64'h0);
        chk("reset nsp", if_nextseqpc, 64'h0);
        chk("reset currentpc", currentpc, spc);
        chk("reset imem_addr", imem_addr, spc);
        @(negedge clk);
        resetl = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [63:0] exp_nsp;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [63:0] rpc,
                                input logic v, input logic [31:0] ins,
                                input logic [63:0] nsp, input logic [63:0] pc);
        vec_t t;
        t.stall     = s;
        t.redir     = r;
        t.rpc       = rpc;
        t.exp_valid = v;
        t.exp_instr = ins;
        t.exp_nsp   = nsp;
        t.exp_pc    = pc;
        return t;
    endfunction

    initial begin
        resetl      = 1'b0;
        startpc     = 64'h100;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        stall       = 1'b0;

        //                 stall redir rpc          valid instr      nsp      pc
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h100, 64'h104, 64'h104)); // first fetch
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h100, 64'h104, 64'h108)); // fill
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h100, 64'h104, 64'h108)); // full hold
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h100, 64'h104, 64'h108));
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h100, 64'h104, 64'h108));
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h104, 64'h108, 64'h10C)); // release
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h108, 64'h10C, 64'h110));
        vecs.push_back(mk(1'b1, 1'b1, 64'h203, 1'b0, 32'h0,   64'h0,   64'h200)); // redir+stall
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h200, 64'h204, 64'h204));
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h204, 64'h208, 64'h208));
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h204, 64'h208, 64'h20C)); // full
        vecs.push_back(mk(1'b0, 1'b1, 64'h300, 1'b0, 32'h0,   64'h0,   64'h300)); // redir full
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h300, 64'h304, 64'h304));
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h304, 64'h308, 64'h308));
        vecs.push_back(mk(1'b0, 1'b1, 64'h400, 1'b0, 32'h0,   64'h0,   64'h400));
        vecs.push_back(mk(1'b0, 1'b1, 64'h501, 1'b0, 32'h0,   64'h0,   64'h500)); // redir empty
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h500, 64'h504, 64'h504));
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h500, 64'h504, 64'h508));
        vecs.push_back(mk(1'b1, 1'b0, 64'h0,   1'b1, 32'h500, 64'h504, 64'h508));
        vecs.push_back(mk(1'b0, 1'b0, 64'h0,   1'b1, 32'h504, 64'h508, 64'h50C));

        // Stream, full queue, redirects.
        apply_reset(64'h100);
        for (int i = 0; i < vecs.size(); i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d valid", i), 64'(if_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d instr", i), 64'(if_instr), 64'(vecs[i].exp_instr));
            chk($sformatf("vec%0d nsp", i), if_nextseqpc, vecs[i].exp_nsp);
            chk($sformatf("vec%0d pc", i), currentpc, vecs[i].exp_pc);
        end
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;

        // PC wrap-around.
        apply_reset(64'hFFFF_FFFF_FFFF_FFFC);
        cycle("wrap1");
        chk("wrap1 instr", 64'(if_instr), 64'hFFFF_FFFC);
        chk("wrap1 nsp", if_nextseqpc, 64'h0);
        chk("wrap1 pc", currentpc, 64'h0);
        cycle("wrap2");
        chk("wrap2 instr", 64'(if_instr), 64'h0);
        chk("wrap2 nsp", if_nextseqpc, 64'h4);
        chk("wrap2 pc", currentpc, 64'h4);

        // Asynchronous reset between edges.
        apply_reset(64'h100);
        cycle("ar1");
        cycle("ar2");
        cycle("ar3");
        chk("ar3 instr", 64'(if_instr), 64'h108);
        #2;
        resetl = 1'b0;
        model_reset(64'h100);
        #1;
        chk("async valid", 64'(if_valid), 64'h0);
        chk("async instr", 64'(if_instr), 64'h0);
        chk("async nsp", if_nextseqpc, 64'h0);
        chk("async pc", currentpc, 64'h100);
        @(negedge clk);
        resetl = 1'b1;
        cycle("restart1");
        chk("restart1 instr", 64'(if_instr), 64'h100);
        chk("restart1 nsp", if_nextseqpc, 64'h104);
        cycle("restart2");
        chk("restart2 instr", 64'(if_instr), 64'h104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
